arm_regfile_mp: RTL
===================

# arm_regfile_mp

Parametrised multi-port register file for the ARM CPU core. It replaces the fixed 16x32, 2-read/1-write file. It adds configurable read and write port counts, registered per-port read enables, deterministic write-port priority, and a per-register pending scoreboard for hazard detection. It sits between decode (read addresses, destination reservation) and writeback (write ports).

## Interface
- DATA_W, 32, register width in bits
- NUM_REGS, 16, number of architectural registers (power of two, ≥2)
- NUM_RD, 3, read ports (Rn, Rm, Rs)
- NUM_WR, 2, write ports (result, base writeback)
- AW (localparam), $clog2(NUM_REGS), register address width
---
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*AW  packed read addresses; port p at [p*AW +: AW]
- rd_data  out  NUM_RD*DATA_W  packed registered read data
- rd_busy  out  NUM_RD  combinational: pending bit of current rd_addr[p]
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*AW  packed write addresses
- wr_data  in  NUM_WR*DATA_W  packed write data
- rsv_en  in  1  reserve destination register (issue)
- rsv_addr  in  AW  register to mark pending
- wr_conflict  out  1  registered flag: two or more enabled write ports targeted the same address in the previous cycle
- pending  out  NUM_REGS  scoreboard vector

## Operation
- Reset: every register is 0, rd_data is 0, pending is 0, and wr_conflict is 0. Writes, reads and reservations in the reset cycle are ignored.
- Read: when rd_en[p]=1, rd_data[p] captures the register at rd_addr[p] on the edge. When rd_en[p]=0, rd_data[p] holds its previous value.
- Write: each enabled port writes wr_data to wr_addr on the edge.
- Same-address write conflict: the highest-index port wins and wr_conflict=1 for the next cycle. Otherwise wr_conflict=0.
- Scoreboard on rsv_en=1: pending[rsv_addr] is set.
- Scoreboard on write: any enabled write port to register r clears pending[r].
- Scoreboard, simultaneous reserve and write to the same r: the set wins and pending[r] stays 1.
- rd_busy[p] = pending[rd_addr[p]], evaluated combinationally before the edge.
- Reads of any address are legal. No register is special-cased.

## Timing
- Read latency is 1 cycle: the address is presented in cycle N and data is valid after edge N.
- Write is visible to a read issued the next cycle: write in N, read in N+1, data after edge N+1 is the new value.
- Same-cycle read/write of the same address: see Configuration.
- pending updates after the edge. rd_busy reflects the new pending value from cycle N+1.
- wr_conflict asserts for exactly one cycle per conflicting cycle.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle write-to-read forwarding. A read in cycle N returns wr_data of the winning write port to that address in cycle N.
- REGFILE_BYPASS_EN undefined: a read in cycle N returns the old contents (read-before-write), matching the previous regfile's behaviour.

## Structure
- Shared package regfile_pkg holds default width/count constants, an unpack helper function for packed address/data slices, and the write-priority resolution function. This lets writeback arbitration reuse the same priority rule.
- One sub-module, regfile_scoreboard, owns pending, rsv logic and rd_busy. The data array, write resolution and read ports stay in the top module.

## Test plan
- Reset, then read all 16 registers on 3 ports → all rd_data=0, pending=0, wr_conflict=0.
- Write R3=0xDEADBEEF on port 0 in N; read R3 in N+1 → 0xDEADBEEF. Read R3 in N → new value with REGFILE_BYPASS_EN defined, 0 without it.
- Ports 0 and 1 both write R5 (0x11, 0x22) → R5=0x22 and wr_conflict=1 for one cycle, then 0.
- rsv_en to R7 → rd_busy=1 when reading R7 next cycle. Write R7 → pending[7]=0. Reserve and write R7 together → pending[7] stays 1.
- rd_en[1]=0 while rd_addr[1] changes from R2 to R4 → rd_data[1] holds the R2 value.
- Assert reset mid-stream with writes pending to R1 and R9 → R1=R9=0, pending=0, write ignored.

Source files
------------

// File: rtl/regfile_pkg.sv
// ============================================================================
// regfile_pkg : shared constants, packed-slice unpack helper and write-port
//               priority resolution for the multi-port register file.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

   localparam int DATA_W_DEF   = 32;
   localparam int NUM_REGS_DEF = 16;
   localparam int NUM_RD_DEF   = 3;
   localparam int NUM_WR_DEF   = 2;

   // Helpers work on fixed maximum widths so any parameterisation up to these
   // bounds can share one definition.
   localparam int VEC_MAX_W = 512;
   localparam int PORT_MAX  = 8;

   typedef logic [VEC_MAX_W-1:0] vec_t;
   typedef logic [PORT_MAX-1:0]  port_vec_t;

   typedef struct packed {
      logic       hit;
      logic       multi;
      logic [2:0] port;
   } wr_res_t;

   function automatic vec_t unpack_field(input vec_t vec, input int idx, input int w);
      vec_t mask;
      mask = (vec_t'(1) << w) - vec_t'(1);
      return (vec >> (idx * w)) & mask;
   endfunction

   function automatic logic write_hits(input port_vec_t en, input vec_t addrs,
                                       input int aw, input int nwr, input vec_t target);
      logic hit;
      hit = 1'b0;
      for (int p = 0; p < PORT_MAX; p++) begin
         if ((p < nwr) && en[p] && (unpack_field(addrs, p, aw) == target)) begin
            hit = 1'b1;
         end
      end
      return hit;
   endfunction

   // Later (higher-index) ports overwrite the selection, so the highest wins.
   function automatic wr_res_t resolve_write(input port_vec_t en, input vec_t addrs,
                                             input int aw, input int nwr, input vec_t target);
      wr_res_t res;
      res = '0;
      for (int p = 0; p < PORT_MAX; p++) begin
         if ((p < nwr) && en[p] && (unpack_field(addrs, p, aw) == target)) begin
            res.multi = res.multi | res.hit;
            res.hit   = 1'b1;
            res.port  = 3'(p);
         end
      end
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// regfile_scoreboard : per-register pending bits, destination reservation and
//                      combinational per-read-port busy flags.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter  int NUM_REGS = NUM_REGS_DEF,
   parameter  int NUM_RD   = NUM_RD_DEF,
   parameter  int NUM_WR   = NUM_WR_DEF,
   localparam int AW       = $clog2(NUM_REGS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rsv_en,
   input  logic [AW-1:0]        rsv_addr,
   input  logic [NUM_WR-1:0]    wr_en,
   input  logic [NUM_WR*AW-1:0] wr_addr,
   input  logic [NUM_RD*AW-1:0] rd_addr,
   output logic [NUM_REGS-1:0]  pending,
   output logic [NUM_RD-1:0]    rd_busy
);

   logic [NUM_REGS-1:0] pending_q;
   logic [NUM_REGS-1:0] pending_d;

   // Clear on write first, then set on reserve so a same-cycle reserve wins.
   always_comb begin
      pending_d = pending_q;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (write_hits(port_vec_t'(wr_en), vec_t'(wr_addr), AW, NUM_WR, vec_t'(r))) begin
            pending_d[r] = 1'b0;
         end
      end
      if (rsv_en) begin
         pending_d[rsv_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   generate
      for (genvar p = 0; p < NUM_RD; p++) begin : g_busy
         assign rd_busy[p] = pending_q[rd_addr[p*AW +: AW]];
      end
   endgenerate

   assign pending = pending_q;

endmodule

`default_nettype wire

// File: rtl/arm_regfile_mp.sv
// ============================================================================
// arm_regfile_mp : parametrised multi-port ARM register file with write-port
//                  priority, conflict flag and pending scoreboard.
// Option         : `define REGFILE_BYPASS_EN for same-cycle write-to-read
//                  forwarding; otherwise reads return pre-write contents.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module arm_regfile_mp
   import regfile_pkg::*;
#(
   parameter  int DATA_W   = DATA_W_DEF,
   parameter  int NUM_REGS = NUM_REGS_DEF,
   parameter  int NUM_RD   = NUM_RD_DEF,
   parameter  int NUM_WR   = NUM_WR_DEF,
   localparam int AW       = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*AW-1:0]     rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*AW-1:0]     wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic                     rsv_en,
   input  logic [AW-1:0]            rsv_addr,
   output logic                     wr_conflict,
   output logic [NUM_REGS-1:0]      pending
);

   logic [DATA_W-1:0] regs_q    [NUM_REGS];
   logic [DATA_W-1:0] regs_d    [NUM_REGS];
   logic [DATA_W-1:0] rd_data_q [NUM_RD];
   logic [DATA_W-1:0] rd_data_d [NUM_RD];
   logic [DATA_W-1:0] wr_data_u [NUM_WR];
   logic [AW-1:0]     rd_addr_u [NUM_RD];
   logic              wr_conflict_q;
   logic              wr_conflict_d;

   always_comb begin
      for (int p = 0; p < NUM_WR; p++) begin
         wr_data_u[p] = DATA_W'(unpack_field(vec_t'(wr_data), p, DATA_W));
      end
   end

   always_comb begin
      for (int p = 0; p < NUM_RD; p++) begin
         rd_addr_u[p] = AW'(unpack_field(vec_t'(rd_addr), p, AW));
      end
   end

   // Per-register next value: winning write port's data, else hold.
   always_comb begin
      wr_res_t res;
      res           = '0;
      wr_conflict_d = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
         regs_d[r] = regs_q[r];
         res = resolve_write(port_vec_t'(wr_en), vec_t'(wr_addr), AW, NUM_WR, vec_t'(r));
         for (int p = 0; p < NUM_WR; p++) begin
            if (res.hit && (int'(res.port) == p)) begin
               regs_d[r] = wr_data_u[p];
            end
         end
         wr_conflict_d = wr_conflict_d | res.multi;
      end
   end

   always_comb begin
      for (int p = 0; p < NUM_RD; p++) begin
         rd_data_d[p] = rd_data_q[p];
         if (rd_en[p]) begin
`ifdef REGFILE_BYPASS_EN
            rd_data_d[p] = regs_d[rd_addr_u[p]];
`else
            rd_data_d[p] = regs_q[rd_addr_u[p]];
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= '0;
         end
         for (int p = 0; p < NUM_RD; p++) begin
            rd_data_q[p] <= '0;
         end
         wr_conflict_q <= 1'b0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= regs_d[r];
         end
         for (int p = 0; p < NUM_RD; p++) begin
            rd_data_q[p] <= rd_data_d[p];
         end
         wr_conflict_q <= wr_conflict_d;
      end
   end

   generate
      for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_out
         assign rd_data[p*DATA_W +: DATA_W] = rd_data_q[p];
      end
   endgenerate

   assign wr_conflict = wr_conflict_q;

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .NUM_RD   (NUM_RD),
      .NUM_WR   (NUM_WR)
   ) u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .rd_addr  (rd_addr),
      .pending  (pending),
      .rd_busy  (rd_busy)
   );

endmodule

`default_nettype wire
